// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the RV32I fetch stage: NOP encoding, reset PC and FSM states.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush > stall > load > bubble, async active-high reset.
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter int          XLEN = 32,
    parameter logic [31:0] NOP  = NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            load_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4_q;
    logic            valid_q;

    // A bubble only needs a NOP and a cleared valid; the PC fields are don't-care.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q    <= NOP;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            instr_q    <= NOP;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (!stall_i) begin
            if (load_i) begin
                instr_q    <= instr_i;
                pc_q       <= pc_i;
                pc_plus4_q <= pc_plus4_i;
                valid_q    <= 1'b1;
            end else begin
                instr_q    <= NOP;
                valid_q    <= 1'b0;
            end
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage of the 5-stage RV32I core: PC register, single-outstanding imem FSM with
// stale-response kill and a one-entry hold buffer, feeding the IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter logic [31:0]     NOP      = NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic            JalrE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] PCF,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [31:0]     buf_instr_q, buf_instr_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pcf_plus4;
    logic            req;
    logic            load;
    logic [31:0]     load_instr;
    logic [XLEN-1:0] load_pc;
    logic [XLEN-1:0] load_pc4;
    logic            unused_tgt_lsbs;

    assign redirect        = PCSrcE | JalrE;
    assign target          = {PCTargetE[XLEN-1:2], 2'b00};
    assign unused_tgt_lsbs = ^PCTargetE[1:0];
    assign pcf_plus4       = pcf_q + XLEN'(4);
    assign load_pc4        = load_pc + XLEN'(4);

    always_comb begin
        state_d     = state_q;
        pcf_d       = pcf_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        req         = 1'b0;
        imem_addr   = pcf_q;
        load        = 1'b0;
        load_instr  = buf_instr_q;
        load_pc     = buf_pc_q;
        unique case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    pcf_d = target;
                end else if (!StallF) begin
                    req     = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pcf_d   = target;
                    state_d = imem_rvalid ? S_IDLE : S_KILL;
                end else if (imem_rvalid) begin
                    pcf_d = pcf_plus4;
                    if (!StallD) begin
                        load       = 1'b1;
                        load_instr = imem_rdata;
                        load_pc    = pcf_q;
                        // Back-to-back issue keeps one instruction per cycle.
                        if (!StallF) begin
                            req       = 1'b1;
                            imem_addr = pcf_plus4;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = pcf_q;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_KILL: begin
                if (redirect) pcf_d = target;
                if (imem_rvalid) state_d = S_IDLE;
            end
            S_HOLD: begin
                if (redirect) begin
                    pcf_d   = target;
                    state_d = S_IDLE;
                end else if (!StallD) begin
                    load    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pcf_q       <= RESET_PC;
            buf_instr_q <= NOP;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pcf_q       <= pcf_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    assign imem_req = req & ~reset;
    assign PCF      = pcf_q;

    if_id_reg #(
        .XLEN (XLEN),
        .NOP  (NOP)
    ) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (FlushD),
        .stall_i    (StallD),
        .load_i     (load),
        .instr_i    (load_instr),
        .pc_i       (load_pc),
        .pc_plus4_i (load_pc4),
        .instr_o    (InstrD),
        .pc_o       (PCD),
        .pc_plus4_o (PCPlus4D),
        .valid_o    (ValidD)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: random-latency imem model, expected program-order
// PC stream rebuilt on every reset/redirect, monitor compares each IF/ID delivery.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOPI   = 32'h0000_0013;

    logic        clk = 1'b0, reset = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0, JalrE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        imem_req, imem_rvalid = 1'b0, ValidD;
    logic [31:0] imem_addr, imem_rdata = '0, PCF, InstrD, PCD, PCPlus4D;

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .NOP(NOPI)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .JalrE(JalrE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .PCF(PCF), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0, deliveries = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[29:0], 2'b11} ^ 32'h1357_9BD0;
    endfunction

    // Expected program-order stream of PCs entering ID.
    logic [31:0] exp_q[$];
    task automatic fill(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    logic e_rst = 1'b1, e_stalld = 1'b0, e_flush = 1'b0;
    initial forever begin
        @(posedge clk);
        e_rst = reset; e_stalld = StallD; e_flush = FlushD;
        if (reset) fill(RST_PC);
        else if (PCSrcE | JalrE) fill({PCTargetE[31:2], 2'b00});
    end

    // Monitor: registered IF/ID outputs just after each edge.
    initial forever begin
        logic [31:0] e;
        @(posedge clk); #1;
        if (!e_rst) begin
            if (e_flush) begin
                chk("flush_valid", {31'd0, ValidD}, 32'd0);
                chk("flush_instr", InstrD, NOPI);
                chk("flush_pcd", PCD, 32'd0);
                chk("flush_pc4", PCPlus4D, 32'd0);
            end else if (!e_stalld) begin
                if (ValidD) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL sb_empty: got PCD %h expected no delivery", PCD);
                    end else begin
                        e = exp_q.pop_front();
                        chk("PCD", PCD, e);
                        chk("InstrD", InstrD, instr_of(e));
                        chk("PCPlus4D", PCPlus4D, e + 32'd4);
                        deliveries++;
                    end
                end else begin
                    chk("bubble_instr", InstrD, NOPI);
                end
            end
        end
    end

    // Instruction memory: one request at a time, latency lat_min..lat_max cycles.
    int          lat_min = 1, lat_max = 1, pend_cnt = 0;
    logic        pend = 1'b0, saw_reset = 1'b0, got_first = 1'b0;
    logic [31:0] paddr = '0, last_req = '0, first_addr = '0;
    initial forever begin
        @(posedge clk); #3;
        if (reset) begin
            pend = 1'b0; imem_rvalid = 1'b0; saw_reset = 1'b1; got_first = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin imem_rvalid = 1'b1; imem_rdata = instr_of(paddr); end
                else pend_cnt--;
            end
        end
        #5;
        if (imem_rvalid) pend = 1'b0;
        if (reset) chk("req_in_reset", {31'd0, imem_req}, 32'd0);
        else if (imem_req) begin
            if (pend) begin
                checks++;
                $display("FAIL two_outstanding: got req %h expected none (pending %h)", imem_addr, paddr);
            end
            pend = 1'b1; paddr = imem_addr; last_req = imem_addr;
            pend_cnt = int'($urandom_range(lat_max, lat_min)) - 1;
            if (saw_reset) begin first_addr = imem_addr; got_first = 1'b1; saw_reset = 1'b0; end
        end
    end

    task automatic next();
        @(posedge clk); #2;
    endtask

    task automatic clear_in();
        StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; JalrE = 0; PCTargetE = '0;
    endtask

    task automatic do_reset();
        clear_in(); reset = 1'b1; next(); next(); reset = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_PCF"}, PCF, RST_PC);
        chk({tag, "_InstrD"}, InstrD, NOPI);
        chk({tag, "_PCD"}, PCD, 32'd0);
        chk({tag, "_PC4"}, PCPlus4D, 32'd0);
        chk({tag, "_ValidD"}, {31'd0, ValidD}, 32'd0);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    endtask

    task automatic chk_first_req(input string tag);
        next(); next();
        chk({tag, "_got_first"}, {31'd0, got_first}, 32'd1);
        chk({tag, "_first_addr"}, first_addr, RST_PC);
    endtask

    initial begin
        int d0, since;
        logic [31:0] t;
        #1 reset = 1'b1;
        next();
        chk_reset_outputs("rst");

        // Latency 1, no hazards: deliveries on every edge from the second one.
        lat_min = 1; lat_max = 1;
        do_reset(); d0 = deliveries;
        repeat (30) next();
        chk("lat1_deliveries", 32'(deliveries - d0), 32'd29);

        // Latency 3: one delivery every third cycle.
        lat_min = 3; lat_max = 3;
        do_reset(); d0 = deliveries;
        repeat (30) next();
        chk("lat3_deliveries", 32'(deliveries - d0), 32'd9);

        // Response for 0x10 arrives under StallF/StallD -> held, then released once.
        lat_min = 1; lat_max = 1;
        do_reset(); repeat (5) next();
        StallF = 1; StallD = 1; next(); next();
        chk("hold_pcd_kept", PCD, 32'h0000_000C);
        chk("hold_pcf", PCF, 32'h0000_0014);
        StallF = 0; StallD = 0; next();
        chk("hold_release_pcd", PCD, 32'h0000_0010);
        next();
        chk("hold_next_req", last_req, 32'h0000_0014);

        // Reset while holding a buffered instruction.
        do_reset(); repeat (5) next();
        StallF = 1; StallD = 1; next();
        reset = 1'b1; #1;
        chk_reset_outputs("rst_hold");
        do_reset(); chk_first_req("rst_hold");

        // Redirect while 0x20 is outstanding -> stale response discarded.
        lat_min = 3; lat_max = 3;
        do_reset(); repeat (25) next();
        PCSrcE = 1; PCTargetE = 32'h0000_0100; next();
        clear_in(); d0 = deliveries;
        repeat (3) next();
        chk("kill_next_req", last_req, 32'h0000_0100);
        chk("kill_no_delivery", 32'(deliveries - d0), 32'd0);

        // Reset while waiting on imem.
        reset = 1'b1; #1;
        chk_reset_outputs("rst_wait");
        do_reset(); chk_first_req("rst_wait");

        // jalr with misaligned target in the same cycle as rvalid, plus FlushD.
        lat_min = 1; lat_max = 1;
        do_reset(); repeat (3) next();
        JalrE = 1; PCTargetE = 32'h0000_0203; FlushD = 1; next();
        clear_in();
        chk("jalr_pcf", PCF, 32'h0000_0200);
        next();
        chk("jalr_next_req", last_req, 32'h0000_0200);

        // Redirect to the top of the address space: PC+4 wraps.
        do_reset(); next();
        PCSrcE = 1; PCTargetE = 32'hFFFF_FFF8; next();
        clear_in(); d0 = deliveries;
        repeat (8) next();
        chk("wrap_deliveries", 32'(deliveries >= d0 + 4), 32'd1);

        // Random hazards, redirects, latencies and occasional resets.
        lat_min = 1; lat_max = 4;
        do_reset(); d0 = deliveries; since = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(199) == 0) begin
                do_reset(); since = 0;
                continue;
            end
            StallD = ($urandom_range(99) < 15);
            StallF = StallD | ($urandom_range(99) < 10);
            if ($urandom_range(99) < 8 || since >= 40) begin
                t = $urandom();
                if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | (t & 32'h0000_000F);
                else t = t & 32'h0000_0FFF;
                PCTargetE = t;
                if ($urandom_range(1) == 0) begin PCSrcE = 1; JalrE = 0; end
                else begin PCSrcE = 0; JalrE = 1; end
                FlushD = 1; since = 0;
            end else begin
                PCSrcE = 0; JalrE = 0; FlushD = 0; since++;
            end
            next();
        end
        clear_in();
        chk("random_liveness", 32'(deliveries - d0 > 300), 32'd1);
        next(); next();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
